cpu_bus_sequencer: RTL and testbench
====================================

CPU_BUS_SEQUENCER -- requirements
Module: cpu_bus_sequencer

Interface
REQ-001 SHALL have parameter INSTR_NUM_BIT, default 8, log2 of instruction-memory depth.
REQ-002 SHALL have parameter BUS_W, default 32, peripheral bus data width.
REQ-003 SHALL have parameter WPI, default 2, bus words per instruction (instruction width = WPI*BUS_W).
REQ-004 SHALL have parameter TMO_W, default 16, watchdog counter width.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, one-cycle batch request, sampled only in IDLE.
REQ-008 SHALL have port instr_count, input, INSTR_NUM_BIT, instructions in batch, sampled with start.
REQ-009 SHALL have port tmo_limit, input, TMO_W, IRQ wait limit in cycles; 0 disables watchdog.
REQ-010 SHALL have port abort, input, 1, synchronous cancel.
REQ-011 SHALL have ports instr_valid (input, 1), instr_ready (output, 1), instr_data (input, WPI*BUS_W): instruction source handshake.
REQ-012 SHALL have ports CPU_instruction_valid (output, 1), CPU_instruction_addr (output, INSTR_NUM_BIT+1), CPU_instruction_data (output, BUS_W): CPU peripheral bus write.
REQ-013 SHALL have port CPU_instruction_irq, input, 1, CPU finish interrupt.
REQ-014 SHALL have ports busy, done, tmo_err, cfg_err (outputs, 1): status; done, tmo_err, cfg_err are one-cycle pulses.

Function
REQ-015 SHALL implement states IDLE, FETCH, WRITE, CMD, WAIT_IRQ, DONE.
REQ-016 IDLE: start with instr_count in 1..2^INSTR_NUM_BIT-1 SHALL latch count, clear instruction index, go to FETCH; busy=1 from next cycle until return to IDLE.
REQ-017 start with instr_count=0 SHALL pulse cfg_err next cycle and stay in IDLE.
REQ-018 FETCH: instr_ready=1 (only here); on instr_valid&&instr_ready SHALL capture instr_data and go to WRITE next cycle.
REQ-019 WRITE: SHALL emit WPI consecutive single-cycle bus writes, word w = instr_data[w*BUS_W +: BUS_W], least-significant word first, addr = index*WPI + w.
REQ-020 After last word: if index+1 < count SHALL increment index and go to FETCH, else go to CMD.
REQ-021 CMD: SHALL emit one write with addr all-ones and data 1 (start command), then go to WAIT_IRQ.
REQ-022 Address all-ones SHALL be reserved for the command; instruction writes never use it (count bound in REQ-016 guarantees this for WPI=2).
REQ-023 WAIT_IRQ: rising edge of CPU_instruction_irq (registered-previous detect) SHALL move to DONE; DONE pulses done for one cycle, then IDLE.
REQ-024 IRQ edges outside WAIT_IRQ SHALL be ignored.
REQ-025 Watchdog: counter cleared on entry to WAIT_IRQ, increments each cycle there; when tmo_limit!=0 and counter reaches tmo_limit SHALL pulse tmo_err and return to IDLE without done.
REQ-026 IRQ edge in the same cycle as timeout SHALL win (done, no tmo_err).
REQ-027 abort in any non-IDLE state SHALL return to IDLE next cycle, no done/tmo_err; any bus write in that cycle completes; abort has priority over all other transitions.
REQ-028 Bus outputs SHALL be registered; when CPU_instruction_valid=0, addr and data SHALL be 0.
REQ-029 Per-instruction cost SHALL be WPI+1 cycles minimum (1 fetch + WPI writes) with instr_valid held high.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, all outputs 0, counters, index and captured instruction 0, irq-edge register 0.
REQ-031 Reset mid-batch SHALL discard the batch; first cycle after release is IDLE.

Structure
REQ-032 Package cpu_bus_pkg SHALL hold the state enum, CMD_DATA=1, and default parameter constants.
REQ-033 Watchdog counter with IRQ edge detect SHALL be sub-module cpu_irq_watchdog; remainder in one module.

Verification
REQ-034 Count=1, instr_data=64'hAAAA_BBBB_CCCC_DDDD -> writes (0x000, 32'hCCCCDDDD), (0x001, 32'hAAAABBBB), (0x1FF, 1); irq after 5 cycles -> done pulse, busy low.
REQ-035 Count=255 with instr_valid always high -> 510 writes, addresses 0x000..0x1FD contiguous, then 0x1FF; 256*3 - 2 = 766 cycles from start to CMD write inclusive (±1 per implementation cycle map documented).
REQ-036 Count=0 -> cfg_err pulse, no bus activity, busy stays 0.
REQ-037 tmo_limit=10, no irq -> tmo_err 10 cycles after CMD write, no done; tmo_limit=0 -> waits indefinitely.
REQ-038 abort during second word of instruction 3 -> IDLE next cycle, no further writes; new start runs cleanly from addr 0.
REQ-039 rst_n asserted in WAIT_IRQ, irq high level held through release -> no done (edge register cleared, no rising edge in WAIT_IRQ).

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU instruction-bus sequencer.
// The command word and default sizing live here so the sub-module and top agree.
package cpu_bus_pkg;

  localparam int unsigned DefInstrNumBit = 8;
  localparam int unsigned DefBusW        = 32;
  localparam int unsigned DefWpi         = 2;
  localparam int unsigned DefTmoW        = 16;

  // Data written to the all-ones address to start the CPU.
  localparam int unsigned CMD_DATA = 1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWrite,
    StCmd,
    StWaitIrq,
    StDone
  } seq_state_e;

endpackage

// File: rtl/cpu_irq_watchdog.sv
// IRQ rising-edge detector and wait-cycle watchdog for the sequencer's IRQ wait.
// The edge register tracks the IRQ every cycle, so a level already high on entry is not an edge.
module cpu_irq_watchdog
  import cpu_bus_pkg::*;
#(
  parameter int unsigned TMO_W = DefTmoW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             run_i,
  input  logic             irq_i,
  input  logic [TMO_W-1:0] tmo_limit_i,
  output logic             irq_rise_o,
  output logic             expire_o
);

  localparam int unsigned CntW = TMO_W + 1;

  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             irq_prev_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  assign irq_rise_o = irq_i & ~irq_prev_q;

  // Fires in the cycle whose increment would make the counter equal the limit.
  assign expire_o = run_i && (tmo_limit_i != '0) &&
                    ((CntW'(cnt_q) + CntW'(1)) == CntW'(tmo_limit_i));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      irq_prev_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      irq_prev_q <= irq_i;
    end
  end

endmodule

// File: rtl/cpu_bus_sequencer.sv
// Streams a batch of instructions onto the CPU peripheral bus one word at a time,
// issues the start command, then waits for the CPU IRQ under an optional watchdog.
module cpu_bus_sequencer
  import cpu_bus_pkg::*;
#(
  parameter int unsigned INSTR_NUM_BIT = DefInstrNumBit,
  parameter int unsigned BUS_W         = DefBusW,
  parameter int unsigned WPI           = DefWpi,
  parameter int unsigned TMO_W         = DefTmoW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [INSTR_NUM_BIT-1:0] instr_count_i,
  input  logic [TMO_W-1:0]         tmo_limit_i,
  input  logic                     abort_i,
  input  logic                     instr_valid_i,
  output logic                     instr_ready_o,
  input  logic [WPI*BUS_W-1:0]     instr_data_i,
  output logic                     CPU_instruction_valid_o,
  output logic [INSTR_NUM_BIT:0]   CPU_instruction_addr_o,
  output logic [BUS_W-1:0]         CPU_instruction_data_o,
  input  logic                     CPU_instruction_irq_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     tmo_err_o,
  output logic                     cfg_err_o
);

  localparam int unsigned AddrW  = INSTR_NUM_BIT + 1;
  localparam int unsigned WordW  = (WPI > 1) ? $clog2(WPI) : 1;
  localparam int unsigned InstrW = WPI * BUS_W;

  seq_state_e               state_q, state_d;
  logic [INSTR_NUM_BIT-1:0] count_q, count_d;
  logic [INSTR_NUM_BIT-1:0] idx_q, idx_d;
  logic [WordW-1:0]         word_q, word_d;
  logic [InstrW-1:0]        instr_q, instr_d;
  logic                     valid_q, valid_d;
  logic [AddrW-1:0]         addr_q, addr_d;
  logic [BUS_W-1:0]         data_q, data_d;
  logic                     tmo_err_q, tmo_err_d;
  logic                     cfg_err_q, cfg_err_d;
  logic                     wd_clear, wd_run, irq_rise, wd_expire;

  cpu_irq_watchdog #(
    .TMO_W(TMO_W)
  ) u_watchdog (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (wd_clear),
    .run_i      (wd_run),
    .irq_i      (CPU_instruction_irq_i),
    .tmo_limit_i(tmo_limit_i),
    .irq_rise_o (irq_rise),
    .expire_o   (wd_expire)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    word_d    = word_q;
    instr_d   = instr_q;
    valid_d   = 1'b0;
    addr_d    = '0;
    data_d    = '0;
    tmo_err_d = 1'b0;
    cfg_err_d = 1'b0;
    wd_clear  = 1'b0;
    wd_run    = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          if (instr_count_i == '0) begin
            cfg_err_d = 1'b1;
          end else begin
            count_d = instr_count_i;
            idx_d   = '0;
            word_d  = '0;
            state_d = StFetch;
          end
        end
      end
      StFetch: begin
        if (instr_valid_i) begin
          instr_d = instr_data_i;
          word_d  = '0;
          state_d = StWrite;
        end
      end
      StWrite: begin
        valid_d = 1'b1;
        addr_d  = AddrW'(32'(idx_q) * WPI + 32'(word_q));
        data_d  = instr_q[32'(word_q) * BUS_W +: BUS_W];
        if (word_q == WordW'(WPI - 1)) begin
          word_d = '0;
          if ((AddrW'(idx_q) + AddrW'(1)) < AddrW'(count_q)) begin
            idx_d   = idx_q + INSTR_NUM_BIT'(1);
            state_d = StFetch;
          end else begin
            state_d = StCmd;
          end
        end else begin
          word_d = word_q + WordW'(1);
        end
      end
      StCmd: begin
        valid_d  = 1'b1;
        addr_d   = '1;
        data_d   = BUS_W'(CMD_DATA);
        wd_clear = 1'b1;
        state_d  = StWaitIrq;
      end
      StWaitIrq: begin
        wd_run = 1'b1;
        // An IRQ edge coinciding with expiry counts as completion.
        if (irq_rise) begin
          state_d = StDone;
        end else if (wd_expire) begin
          tmo_err_d = 1'b1;
          state_d   = StIdle;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides everything; a write already on the bus this cycle still completes.
    if (abort_i && (state_q != StIdle)) begin
      state_d   = StIdle;
      valid_d   = 1'b0;
      addr_d    = '0;
      data_d    = '0;
      tmo_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      count_q   <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      tmo_err_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      tmo_err_q <= tmo_err_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign instr_ready_o           = (state_q == StFetch);
  assign CPU_instruction_valid_o = valid_q;
  assign CPU_instruction_addr_o  = addr_q;
  assign CPU_instruction_data_o  = data_q;
  assign busy_o                  = (state_q != StIdle);
  assign done_o                  = (state_q == StDone);
  assign tmo_err_o               = tmo_err_q;
  assign cfg_err_o               = cfg_err_q;

endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// Scoreboard bench for cpu_bus_sequencer: a batch-level model queues the expected bus
// writes and status pulses; a negedge monitor pops and compares whatever the DUT presents.
module tb_cpu_bus_sequencer;

  localparam int unsigned INB = 8;
  localparam int unsigned BW  = 32;
  localparam int unsigned WPI = 2;
  localparam int unsigned TW  = 16;
  localparam int unsigned AW  = INB + 1;
  localparam int unsigned IW  = WPI * BW;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [INB-1:0] instr_count;
  logic [TW-1:0]  tmo_limit;
  logic           abort;
  logic           instr_valid;
  logic           instr_ready;
  logic [IW-1:0]  instr_data;
  logic           cpu_valid;
  logic [AW-1:0]  cpu_addr;
  logic [BW-1:0]  cpu_data;
  logic           cpu_irq;
  logic           busy, done, tmo_err, cfg_err;

  always #5 clk = ~clk;

  cpu_bus_sequencer #(
    .INSTR_NUM_BIT(INB),
    .BUS_W        (BW),
    .WPI          (WPI),
    .TMO_W        (TW)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .start_i                (start),
    .instr_count_i          (instr_count),
    .tmo_limit_i            (tmo_limit),
    .abort_i                (abort),
    .instr_valid_i          (instr_valid),
    .instr_ready_o          (instr_ready),
    .instr_data_i           (instr_data),
    .CPU_instruction_valid_o(cpu_valid),
    .CPU_instruction_addr_o (cpu_addr),
    .CPU_instruction_data_o (cpu_data),
    .CPU_instruction_irq_i  (cpu_irq),
    .busy_o                 (busy),
    .done_o                 (done),
    .tmo_err_o              (tmo_err),
    .cfg_err_o              (cfg_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [BW-1:0] exp_data_q[$];
  int            exp_evt_q[$];   // 1 = done, 2 = tmo_err, 4 = cfg_err
  logic [IW-1:0] src_q[$];
  bit            gap_en = 1'b0;

  int wr_cnt = 0, cmd_cnt = 0, cmd_cyc = 0;
  int done_cnt = 0, tmo_cnt = 0, tmo_cyc = 0, cfg_cnt = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compares every bus write and status pulse against the scoreboard.
  initial begin
    logic [AW-1:0] ea;
    logic [BW-1:0] ed;
    int            got_evt, want_evt;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        checks++;
        if (cpu_valid) begin
          wr_cnt++;
          if (cpu_addr == {AW{1'b1}}) begin
            cmd_cnt++;
            cmd_cyc = cyc;
          end
          if (exp_addr_q.size() == 0) begin
            errors++;
            $display("FAIL bus_write: got addr=%0h data=%0h, required no write", cpu_addr,
                     cpu_data);
          end else begin
            ea = exp_addr_q.pop_front();
            ed = exp_data_q.pop_front();
            if (cpu_addr !== ea || cpu_data !== ed) begin
              errors++;
              $display("FAIL bus_write: got addr=%0h data=%0h, required addr=%0h data=%0h",
                       cpu_addr, cpu_data, ea, ed);
            end
          end
        end else if (cpu_addr !== '0 || cpu_data !== '0) begin
          errors++;
          $display("FAIL idle_bus: got addr=%0h data=%0h, required 0/0", cpu_addr, cpu_data);
        end
        got_evt = {29'd0, cfg_err, tmo_err, done};
        if (done) done_cnt++;
        if (tmo_err) begin
          tmo_cnt++;
          tmo_cyc = cyc;
        end
        if (cfg_err) cfg_cnt++;
        if (got_evt != 0) begin
          checks++;
          want_evt = (exp_evt_q.size() == 0) ? 0 : exp_evt_q.pop_front();
          if (got_evt != want_evt) begin
            errors++;
            $display("FAIL status_pulse: got code %0d, required code %0d", got_evt, want_evt);
          end
        end
      end
    end
  end

  // Instruction source: presents queued instructions, optionally with random bubbles.
  initial begin
    bit hs;
    instr_valid = 1'b0;
    instr_data  = '0;
    forever begin
      @(negedge clk);
      hs = instr_valid && instr_ready;
      @(posedge clk);
      #1;
      if (hs && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0 && (!gap_en || $urandom_range(3) != 0)) begin
        instr_valid = 1'b1;
        instr_data  = src_q[0];
      end else begin
        instr_valid = 1'b0;
        instr_data  = '0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  function automatic int sel(input int which);
    case (which)
      0:       return wr_cnt;
      1:       return cmd_cnt;
      2:       return done_cnt;
      3:       return tmo_cnt;
      default: return cfg_cnt;
    endcase
  endfunction

  task automatic wait_until(input int which, input int target, input int bound,
                            input string name);
    bit ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (sel(which) >= target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok && sel(which) >= target) ok = 1'b1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got no event within %0d cycles, required count %0d", name, bound,
               target);
    end
  endtask

  // Reference model: instruction i occupies addresses i*WPI .. i*WPI+WPI-1, low word first,
  // and the batch ends with the command word at the all-ones address.
  task automatic build_batch(input int n, input int keep_words);
    logic [IW-1:0] ins;
    int nw = 0;
    for (int i = 0; i < n; i++) begin
      for (int w = 0; w < WPI; w++) ins[w*BW +: BW] = BW'($urandom());
      src_q.push_back(ins);
      for (int w = 0; w < WPI; w++) begin
        if (keep_words < 0 || nw < keep_words) begin
          exp_addr_q.push_back(AW'(i * WPI + w));
          exp_data_q.push_back(ins[w*BW +: BW]);
        end
        nw++;
      end
    end
    if (keep_words < 0) begin
      exp_addr_q.push_back({AW{1'b1}});
      exp_data_q.push_back(BW'(1));
    end
  endtask

  task automatic pulse_start(input int n);
    start       = 1'b1;
    instr_count = INB'(n);
    tick();
    start       = 1'b0;
    instr_count = '0;
  endtask

  // irq_dly < 0: no IRQ, expect a timeout when tmo != 0.
  task automatic run_flow(input int n, input int tmo, input int irq_dly, input bit gaps,
                          output int c0);
    int base_cmd, base_done, base_tmo;
    gap_en    = gaps;
    tmo_limit = TW'(tmo);
    base_cmd  = cmd_cnt;
    base_done = done_cnt;
    base_tmo  = tmo_cnt;
    if (irq_dly >= 0) exp_evt_q.push_back(1);
    else if (tmo != 0) exp_evt_q.push_back(2);
    c0 = cyc;
    pulse_start(n);
    check("busy_after_start", 64'(busy), 64'(1));
    wait_until(1, base_cmd + 1, n * (WPI + 1) * 6 + 40, "cmd_write");
    if (irq_dly >= 0) begin
      repeat (irq_dly) tick();
      check("still_waiting", 64'(busy), 64'(1));
      cpu_irq = 1'b1;
      wait_until(2, base_done + 1, 20, "done_pulse");
      check("busy_after_done", 64'(busy), 64'(0));
      check("no_tmo_with_done", 64'(tmo_cnt - base_tmo), 64'(0));
      cpu_irq = 1'b0;
    end else if (tmo != 0) begin
      wait_until(3, base_tmo + 1, tmo + 20, "tmo_err");
      check("tmo_latency", 64'(tmo_cyc - cmd_cyc), 64'(tmo));
      check("busy_after_tmo", 64'(busy), 64'(0));
      check("no_done_on_tmo", 64'(done_cnt - base_done), 64'(0));
    end
    tick();
  endtask

  initial begin
    int c0, base, n, dly, tmo;
    rst_n       = 1'b0;
    start       = 1'b0;
    instr_count = '0;
    tmo_limit   = '0;
    abort       = 1'b0;
    cpu_irq     = 1'b0;
    #2;
    check("reset_outputs", 64'({busy, cpu_valid, cpu_addr, cpu_data, done, tmo_err, cfg_err,
                               instr_ready}), 64'(0));
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Directed single instruction with spec-given words.
    src_q.push_back(64'hAAAA_BBBB_CCCC_DDDD);
    exp_addr_q.push_back(9'h000); exp_data_q.push_back(32'hCCCC_DDDD);
    exp_addr_q.push_back(9'h001); exp_data_q.push_back(32'hAAAA_BBBB);
    exp_addr_q.push_back(9'h1FF); exp_data_q.push_back(32'h0000_0001);
    run_flow(1, 0, 5, 1'b0, c0);

    // Zero-length batch is rejected.
    base = cfg_cnt;
    n = wr_cnt;
    exp_evt_q.push_back(4);
    pulse_start(0);
    wait_until(4, base + 1, 5, "cfg_err");
    for (int i = 0; i < 3; i++) begin
      check("busy_after_cfg_err", 64'(busy), 64'(0));
      tick();
    end
    check("no_writes_on_cfg_err", 64'(wr_cnt - n), 64'(0));

    // Full-depth batch: start presented in cycle 0, command write on the bus in cycle 767.
    base = wr_cnt;
    build_batch(255, -1);
    run_flow(255, 0, 3, 1'b0, c0);
    check("full_batch_writes", 64'(wr_cnt - base), 64'(511));
    check("full_batch_cmd_latency", 64'(cmd_cyc - c0), 64'(767));

    // Watchdog: timeout, IRQ tying with expiry, and disabled watchdog.
    build_batch(2, -1);
    run_flow(2, 10, -1, 1'b0, c0);
    build_batch(2, -1);
    run_flow(2, 10, 8, 1'b0, c0);
    build_batch(1, -1);
    run_flow(1, 0, 300, 1'b0, c0);

    // IRQ level already high before WAIT_IRQ is not an edge.
    cpu_irq = 1'b1;
    build_batch(2, -1);
    run_flow(2, 12, -1, 1'b1, c0);
    cpu_irq = 1'b0;
    tick();

    // Abort while the second word of instruction 3 is on the bus.
    gap_en = 1'b0;
    base = wr_cnt;
    n = done_cnt + tmo_cnt;
    build_batch(5, 6);
    pulse_start(5);
    dly = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (wr_cnt >= base + 6) begin
        dly = 1;
        break;
      end
    end
    check("abort_point_reached", 64'(dly), 64'(1));
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    src_q.delete();
    check("busy_after_abort", 64'(busy), 64'(0));
    repeat (20) tick();
    check("writes_after_abort", 64'(wr_cnt - base), 64'(6));
    check("no_status_after_abort", 64'(done_cnt + tmo_cnt - n), 64'(0));
    build_batch(2, -1);
    run_flow(2, 0, 2, 1'b1, c0);

    // Reset in WAIT_IRQ with IRQ high across release.
    base = cmd_cnt;
    n = done_cnt;
    build_batch(2, -1);
    pulse_start(2);
    wait_until(1, base + 1, 60, "cmd_before_reset");
    tick();
    rst_n = 1'b0;
    #1;
    cpu_irq = 1'b1;
    #1;
    check("outputs_in_reset", 64'({busy, cpu_valid, cpu_addr, cpu_data, done, tmo_err}),
          64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    check("busy_after_release", 64'(busy), 64'(0));
    repeat (10) tick();
    check("no_done_after_reset", 64'(done_cnt - n), 64'(0));
    cpu_irq = 1'b0;
    tick();

    // Randomized batches: completion under random watchdog limits, then pure timeouts.
    for (int r = 0; r < 6; r++) begin
      n   = $urandom_range(8, 1);
      dly = $urandom_range(6, 0);
      tmo = ($urandom_range(1, 0) == 0) ? 0 : dly + 2 + $urandom_range(10, 0);
      build_batch(n, -1);
      run_flow(n, tmo, dly, 1'b1, c0);
    end
    for (int r = 0; r < 3; r++) begin
      n   = $urandom_range(6, 1);
      tmo = $urandom_range(15, 1);
      build_batch(n, -1);
      run_flow(n, tmo, -1, 1'b1, c0);
    end

    repeat (5) tick();
    check("writes_drained", 64'(exp_addr_q.size()), 64'(0));
    check("events_drained", 64'(exp_evt_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
